gin_multicast_rx: RTL and testbench
===================================

Name: gin_multicast_rx

Overview:
- Receiving end of the GIN handshake that the array controller drives.
- Holds per-PE ifmap/filter/ipsum X/Y IDs, loaded through the X/Y scan chains, and the LN config word.
- Accepts one tagged word per handshake from the controller and multicasts it to every PE whose stored IDs match the tags, using per-PE valid/ready.
- Sits between the controller and the PE array; one buffered transaction in flight, full throughput.

Parameters:
NUMS_PE_ROW, 6, PE array rows
NUMS_PE_COL, 8, PE array columns
XID_BITS, 5, X ID / X tag width
YID_BITS, 3, Y ID / Y tag width
DATA_SIZE, 32, GIN data width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
set_XID  in  1  shift X chains one PE position
ifmap_XID_scan_in / filter_XID_scan_in / ipsum_XID_scan_in  in  XID_BITS each  X scan data
set_YID  in  1  shift Y chains one row position
ifmap_YID_scan_in / filter_YID_scan_in / ipsum_YID_scan_in  in  YID_BITS each  Y scan data
set_LN  in  1  load LN config
LN_config_in  in  NUMS_PE_ROW-1  LN config value
LN_config  out  NUMS_PE_ROW-1  registered LN config to local network
ifmap_tag_X, filter_tag_X, ipsum_tag_X  in  XID_BITS  X tags
ifmap_tag_Y, filter_tag_Y, ipsum_tag_Y  in  YID_BITS  Y tags
GLB_ifmap_valid / GLB_filter_valid / GLB_ipsum_valid  in  1  class valid
GLB_ifmap_ready / GLB_filter_ready / GLB_ipsum_ready  out  1  class ready
PE_data_in  in  DATA_SIZE  GIN data
PE_valid  out  NUMS_PE_ROW*NUMS_PE_COL  per-PE valid
PE_ready  in  NUMS_PE_ROW*NUMS_PE_COL  per-PE ready
PE_data  out  DATA_SIZE  broadcast data
PE_class  out  2  0 = ifmap, 1 = filter, 2 = ipsum
drop_err  out  1  one-cycle pulse: accepted word had no target

Behaviour:
- PE index k = row*NUMS_PE_COL + col. N = NUMS_PE_ROW*NUMS_PE_COL.
- Reset (rst == 0 at posedge):
  - All ID registers and LN_config cleared to 0.
  - Buffer emptied; PE_valid = 0, PE_data = 0, PE_class = 0, drop_err = 0.
  - Any in-flight transaction is discarded.
- X scan: each cycle set_XID = 1, for each class xid[k] <= xid[k+1] for k < N-1, and xid[N-1] <= scan_in. After N consecutive shifts, the first value sent sits in PE 0.
- Y scan: same scheme over NUMS_PE_ROW row registers. The first of NUMS_PE_ROW shifts lands in row 0.
- X and Y scans are independent and may shift in the same cycle.
- set_LN: LN_config <= LN_config_in at the next edge.
- Class select, fixed priority filter > ifmap > ipsum among the valid inputs. Only the selected class's ready may be 1; the other class readies are 0.
- Buffer state is the pending mask P (N bits). Empty means P == 0. Define done = ((P & ~PE_ready) == 0).
- Ready: the selected class's ready = done. This is combinational, and it is 1 when the buffer is empty.
- Accept (selected valid & ready):
  - mask[k] = (xid_c[k] == tag_X_c) & (ydd_c[row(k)] == tag_Y_c).
  - Next cycle: P <= mask, PE_data <= PE_data_in, PE_class <= class.
  - Mask is frozen at accept; later scans do not alter an in-flight transaction.
- PE handshake:
  - PE_valid = P.
  - Each cycle, P <= P & ~PE_ready unless a new accept overwrites P.
  - A PE completes on PE_valid[k] & PE_ready[k] and is never offered the same word again.
- Simultaneous last completion and new accept: the new word loads in the same edge. Sustained throughput is 1 word/cycle when all targets are ready.
- Zero-target accept (mask == 0): the word is consumed, P stays 0, and drop_err pulses for 1 cycle.
- No valid input: P keeps draining; PE_data and PE_class hold.
- Valid without ready (buffer busy): the controller holds; nothing is latched.
- Latency: accept edge to PE_valid high is 1 cycle.
- ID/tag compare is exact equality at full width; no wrap or arithmetic.

Test Plan:
1. Reset mid-transfer: accept a filter word, hold PE_ready = 0, assert rst = 0 for 1 cycle -> PE_valid = 0, P = 0, GLB_filter_ready = 1 the next cycle; all IDs read back 0 (ifmap tag 0/0 then targets all 48 PEs).
2. Scan load:
   - Stimulus: shift filter X IDs k%8 for k = 0..47 and Y IDs 0..5; send filter_tag_X = 3, tag_Y = 2, data 0xDEADBEEF.
   - Required: PE_valid has only bit 19 set, PE_data = 0xDEADBEEF, PE_class = 1.
3. Multicast with staggered readies:
   - Stimulus: ifmap X IDs all 0, Y IDs 0..5, tag 0/1 (8 PEs, bits 8..15); PE_ready for bits 8..11 at cycle 1, bits 12..15 at cycle 3.
   - Required: PE_valid goes 0xFF00 -> 0xF000 -> 0; GLB_ifmap_ready returns to 1 in cycle 3.
4. Back-to-back throughput: 16 ipsum words with all PE_ready = 1 -> one accept per cycle, no bubbles, PE_data sequence matches the input.
5. Priority: filter and ifmap valid in the same cycle -> GLB_filter_ready = 1, GLB_ifmap_ready = 0; ifmap is accepted after the filter valid drops.
6. Drop: tag_X = 31 matches no PE -> drop_err pulses once, PE_valid stays 0, and the next word is accepted immediately.

Source files
------------

// File: rtl/gin_multicast_rx_if.sv
// gin_multicast_rx_if: controller-to-PE handshake bundle for the GIN multicast receiver.
// Carries the three tagged class inputs (valid/ready, X/Y tags), the shared data word,
// and the per-PE valid/ready fan-out with broadcast data, class and drop pulse.
interface gin_multicast_rx_if #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 3,
  parameter int DATA_SIZE   = 32
);
  localparam int N = NUMS_PE_ROW * NUMS_PE_COL;

  // controller side
  logic [XID_BITS-1:0]  ifmap_tag_X;
  logic [XID_BITS-1:0]  filter_tag_X;
  logic [XID_BITS-1:0]  ipsum_tag_X;
  logic [YID_BITS-1:0]  ifmap_tag_Y;
  logic [YID_BITS-1:0]  filter_tag_Y;
  logic [YID_BITS-1:0]  ipsum_tag_Y;
  logic                 GLB_ifmap_valid;
  logic                 GLB_filter_valid;
  logic                 GLB_ipsum_valid;
  logic                 GLB_ifmap_ready;
  logic                 GLB_filter_ready;
  logic                 GLB_ipsum_ready;
  logic [DATA_SIZE-1:0] PE_data_in;

  // PE array side
  logic [N-1:0]         PE_valid;
  logic [N-1:0]         PE_ready;
  logic [DATA_SIZE-1:0] PE_data;
  logic [1:0]           PE_class;
  logic                 drop_err;

  // environment: drives tags/valids/data and PE readies
  modport master (
    output ifmap_tag_X, filter_tag_X, ipsum_tag_X,
    output ifmap_tag_Y, filter_tag_Y, ipsum_tag_Y,
    output GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid,
    input  GLB_ifmap_ready, GLB_filter_ready, GLB_ipsum_ready,
    output PE_data_in,
    input  PE_valid, PE_data, PE_class, drop_err,
    output PE_ready
  );

  // receiver
  modport slave (
    input  ifmap_tag_X, filter_tag_X, ipsum_tag_X,
    input  ifmap_tag_Y, filter_tag_Y, ipsum_tag_Y,
    input  GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid,
    output GLB_ifmap_ready, GLB_filter_ready, GLB_ipsum_ready,
    input  PE_data_in,
    output PE_valid, PE_data, PE_class, drop_err,
    input  PE_ready
  );
endinterface

// File: rtl/gin_multicast_rx.sv
// gin_multicast_rx: GIN receiver; holds scan-loaded per-PE X/Y IDs and LN config, accepts one
// tagged word per handshake and multicasts it to every matching PE. Latency: accept to PE_valid 1 cycle.
// Backpressure: selected class ready = all pending PEs done this cycle; new word loads on last completion.
// Ports: clk/rst (sync, active-low), X/Y scan chains + set_LN/LN_config, gin (slave modport) handshake.
module gin_multicast_rx #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 3,
  parameter int DATA_SIZE   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_XID,
  input  logic [XID_BITS-1:0]    ifmap_XID_scan_in,
  input  logic [XID_BITS-1:0]    filter_XID_scan_in,
  input  logic [XID_BITS-1:0]    ipsum_XID_scan_in,
  input  logic                   set_YID,
  input  logic [YID_BITS-1:0]    ifmap_YID_scan_in,
  input  logic [YID_BITS-1:0]    filter_YID_scan_in,
  input  logic [YID_BITS-1:0]    ipsum_YID_scan_in,
  input  logic                   set_LN,
  input  logic [NUMS_PE_ROW-2:0] LN_config_in,
  output logic [NUMS_PE_ROW-2:0] LN_config,
  gin_multicast_rx_if.slave      gin
);
  localparam int N = NUMS_PE_ROW * NUMS_PE_COL;

  localparam logic [1:0] CLS_IFMAP  = 2'd0;
  localparam logic [1:0] CLS_FILTER = 2'd1;
  localparam logic [1:0] CLS_IPSUM  = 2'd2;

  // ID storage: X IDs per PE, Y IDs per row
  logic [XID_BITS-1:0] ifmap_xid_q  [N];
  logic [XID_BITS-1:0] filter_xid_q [N];
  logic [XID_BITS-1:0] ipsum_xid_q  [N];
  logic [YID_BITS-1:0] ifmap_yid_q  [NUMS_PE_ROW];
  logic [YID_BITS-1:0] filter_yid_q [NUMS_PE_ROW];
  logic [YID_BITS-1:0] ipsum_yid_q  [NUMS_PE_ROW];
  logic [NUMS_PE_ROW-2:0] ln_q;

  // buffered transaction
  logic [N-1:0]         pend_q,  pend_d;
  logic [DATA_SIZE-1:0] data_q,  data_d;
  logic [1:0]           cls_q,   cls_d;
  logic                 drop_q,  drop_d;

  logic                 sel_filter, sel_ifmap, sel_ipsum, sel_vld;
  logic                 done, accept;
  logic [1:0]           sel_cls;
  logic [N-1:0]         ifmap_hit, filter_hit, ipsum_hit, mask;

  // fixed priority filter > ifmap > ipsum
  assign sel_filter = gin.GLB_filter_valid;
  assign sel_ifmap  = gin.GLB_ifmap_valid & ~gin.GLB_filter_valid;
  assign sel_ipsum  = gin.GLB_ipsum_valid & ~gin.GLB_filter_valid & ~gin.GLB_ifmap_valid;
  assign sel_vld    = sel_filter | sel_ifmap | sel_ipsum;
  assign sel_cls    = sel_filter ? CLS_FILTER : (sel_ifmap ? CLS_IFMAP : CLS_IPSUM);

  // every pending PE either already finished or completes this cycle
  assign done   = ((pend_q & ~gin.PE_ready) == '0);
  assign accept = sel_vld & done;

  assign gin.GLB_filter_ready = sel_filter & done;
  assign gin.GLB_ifmap_ready  = sel_ifmap  & done;
  assign gin.GLB_ipsum_ready  = sel_ipsum  & done;

  // per-class target match against stored IDs; row of PE k is k / NUMS_PE_COL
  always_comb begin
    ifmap_hit  = '0;
    filter_hit = '0;
    ipsum_hit  = '0;
    for (int k = 0; k < N; k++) begin
      ifmap_hit[k]  = (ifmap_xid_q[k]  == gin.ifmap_tag_X)  &&
                      (ifmap_yid_q[k / NUMS_PE_COL]  == gin.ifmap_tag_Y);
      filter_hit[k] = (filter_xid_q[k] == gin.filter_tag_X) &&
                      (filter_yid_q[k / NUMS_PE_COL] == gin.filter_tag_Y);
      ipsum_hit[k]  = (ipsum_xid_q[k]  == gin.ipsum_tag_X)  &&
                      (ipsum_yid_q[k / NUMS_PE_COL]  == gin.ipsum_tag_Y);
    end
  end

  always_comb begin
    mask = '0;
    case (sel_cls)
      CLS_FILTER: mask = filter_hit;
      CLS_IFMAP:  mask = ifmap_hit;
      default:    mask = ipsum_hit;
    endcase
  end

  // a new accept overwrites the pending mask; otherwise completed PEs drop out
  always_comb begin
    pend_d = pend_q & ~gin.PE_ready;
    data_d = data_q;
    cls_d  = cls_q;
    drop_d = 1'b0;
    if (accept) begin
      pend_d = mask;
      data_d = gin.PE_data_in;
      cls_d  = sel_cls;
      drop_d = (mask == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
      data_q <= '0;
      cls_q  <= CLS_IFMAP;
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
      cls_q  <= cls_d;
      drop_q <= drop_d;
    end
  end

  // X chains: shift toward PE 0, so the first value sent ends up in PE 0 after N shifts
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        ifmap_xid_q[k]  <= '0;
        filter_xid_q[k] <= '0;
        ipsum_xid_q[k]  <= '0;
      end
    end else if (set_XID) begin
      for (int k = 0; k < N-1; k++) begin
        ifmap_xid_q[k]  <= ifmap_xid_q[k+1];
        filter_xid_q[k] <= filter_xid_q[k+1];
        ipsum_xid_q[k]  <= ipsum_xid_q[k+1];
      end
      ifmap_xid_q[N-1]  <= ifmap_XID_scan_in;
      filter_xid_q[N-1] <= filter_XID_scan_in;
      ipsum_xid_q[N-1]  <= ipsum_XID_scan_in;
    end
  end

  // Y chains: same scheme over rows
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUMS_PE_ROW; r++) begin
        ifmap_yid_q[r]  <= '0;
        filter_yid_q[r] <= '0;
        ipsum_yid_q[r]  <= '0;
      end
    end else if (set_YID) begin
      for (int r = 0; r < NUMS_PE_ROW-1; r++) begin
        ifmap_yid_q[r]  <= ifmap_yid_q[r+1];
        filter_yid_q[r] <= filter_yid_q[r+1];
        ipsum_yid_q[r]  <= ipsum_yid_q[r+1];
      end
      ifmap_yid_q[NUMS_PE_ROW-1]  <= ifmap_YID_scan_in;
      filter_yid_q[NUMS_PE_ROW-1] <= filter_YID_scan_in;
      ipsum_yid_q[NUMS_PE_ROW-1]  <= ipsum_YID_scan_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ln_q <= '0;
    end else if (set_LN) begin
      ln_q <= LN_config_in;
    end
  end

  assign LN_config    = ln_q;
  assign gin.PE_valid = pend_q;
  assign gin.PE_data  = data_q;
  assign gin.PE_class = cls_q;
  assign gin.drop_err = drop_q;

endmodule

// File: tb/tb_gin_multicast_rx.sv
// tb_gin_multicast_rx: directed-vector bench for gin_multicast_rx with hand-computed expectations.
module tb_gin_multicast_rx;
  localparam int NR = 6;
  localparam int NC = 8;
  localparam int XB = 5;
  localparam int YB = 3;
  localparam int DW = 32;
  localparam int N  = NR * NC;
  localparam logic [N-1:0] ALL = {N{1'b1}};

  logic          clk = 1'b0;
  logic          rst;
  logic          set_XID, set_YID, set_LN;
  logic [XB-1:0] ifmap_XID_scan_in, filter_XID_scan_in, ipsum_XID_scan_in;
  logic [YB-1:0] ifmap_YID_scan_in, filter_YID_scan_in, ipsum_YID_scan_in;
  logic [NR-2:0] LN_config_in, LN_config;

  int n_chk  = 0;
  int n_pass = 0;

  gin_multicast_rx_if #(.NUMS_PE_ROW(NR), .NUMS_PE_COL(NC), .XID_BITS(XB),
                        .YID_BITS(YB), .DATA_SIZE(DW)) gin ();

  gin_multicast_rx #(.NUMS_PE_ROW(NR), .NUMS_PE_COL(NC), .XID_BITS(XB),
                     .YID_BITS(YB), .DATA_SIZE(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .set_XID            (set_XID),
    .ifmap_XID_scan_in  (ifmap_XID_scan_in),
    .filter_XID_scan_in (filter_XID_scan_in),
    .ipsum_XID_scan_in  (ipsum_XID_scan_in),
    .set_YID            (set_YID),
    .ifmap_YID_scan_in  (ifmap_YID_scan_in),
    .filter_YID_scan_in (filter_YID_scan_in),
    .ipsum_YID_scan_in  (ipsum_YID_scan_in),
    .set_LN             (set_LN),
    .LN_config_in       (LN_config_in),
    .LN_config          (LN_config),
    .gin                (gin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // inputs change 1 time unit after the rising edge; registered outputs are stable there
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle on freshly driven inputs
  task automatic settle();
    #1;
  endtask

  // shift all three X chains N times and Y chains NR times (overlapping)
  // xmode: 0 -> all classes value xc; 1 -> filter/ipsum k%8, ifmap 0
  task automatic scan_load(input int xmode, input logic [XB-1:0] xc, input int ymode, input logic [YB-1:0] yc);
    for (int k = 0; k < N; k++) begin
      set_XID = 1'b1;
      if (xmode == 0) begin
        ifmap_XID_scan_in  = xc;
        filter_XID_scan_in = xc;
        ipsum_XID_scan_in  = xc;
      end else begin
        ifmap_XID_scan_in  = '0;
        filter_XID_scan_in = XB'(k % NC);
        ipsum_XID_scan_in  = XB'(k % NC);
      end
      set_YID = (k < NR);
      ifmap_YID_scan_in  = (ymode == 0) ? yc : YB'(k);
      filter_YID_scan_in = (ymode == 0) ? yc : YB'(k);
      ipsum_YID_scan_in  = (ymode == 0) ? yc : YB'(k);
      step();
    end
    set_XID = 1'b0;
    set_YID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    set_XID = 0; set_YID = 0; set_LN = 0; LN_config_in = '0;
    ifmap_XID_scan_in = '0; filter_XID_scan_in = '0; ipsum_XID_scan_in = '0;
    ifmap_YID_scan_in = '0; filter_YID_scan_in = '0; ipsum_YID_scan_in = '0;
    gin.ifmap_tag_X = '0; gin.filter_tag_X = '0; gin.ipsum_tag_X = '0;
    gin.ifmap_tag_Y = '0; gin.filter_tag_Y = '0; gin.ipsum_tag_Y = '0;
    gin.GLB_ifmap_valid = 0; gin.GLB_filter_valid = 0; gin.GLB_ipsum_valid = 0;
    gin.PE_data_in = '0;
    gin.PE_ready = '0;
    step();
    step();

    // reset state
    chk("rst_pe_valid", 64'(gin.PE_valid), 64'h0);
    chk("rst_pe_data",  64'(gin.PE_data),  64'h0);
    chk("rst_pe_class", 64'(gin.PE_class), 64'h0);
    chk("rst_drop",     64'(gin.drop_err), 64'h0);
    chk("rst_ln",       64'(LN_config),    64'h0);
    rst = 1'b1;

    // LN config load
    set_LN = 1'b1; LN_config_in = 5'h15;
    step();
    set_LN = 1'b0; LN_config_in = 5'h0A;
    step();
    chk("ln_load_hold", 64'(LN_config), 64'h15);

    // 1: reset mid-transfer; IDs X=5 / Y=1 everywhere, so filter 5/1 hits all PEs
    scan_load(0, 5'd5, 0, 3'd1);
    gin.filter_tag_X = 5'd5; gin.filter_tag_Y = 3'd1;
    gin.GLB_filter_valid = 1'b1; gin.PE_data_in = 32'h1111_1111;
    settle();
    chk("t1_filter_rdy_empty", 64'(gin.GLB_filter_ready), 64'h1);
    step();
    gin.GLB_filter_valid = 1'b0;
    chk("t1_pe_valid_all", 64'(gin.PE_valid), 64'(ALL));
    step();
    chk("t1_pe_valid_held", 64'(gin.PE_valid), 64'(ALL));
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t1_post_rst_valid", 64'(gin.PE_valid), 64'h0);
    chk("t1_post_rst_data",  64'(gin.PE_data),  64'h0);
    chk("t1_post_rst_ln",    64'(LN_config),    64'h0);
    gin.GLB_filter_valid = 1'b1;
    settle();
    chk("t1_post_rst_filter_rdy", 64'(gin.GLB_filter_ready), 64'h1);
    gin.GLB_filter_valid = 1'b0;
    gin.ifmap_tag_X = 5'd0; gin.ifmap_tag_Y = 3'd0;
    gin.GLB_ifmap_valid = 1'b1; gin.PE_data_in = 32'h2222_2222;
    settle();
    chk("t1_ifmap_rdy", 64'(gin.GLB_ifmap_ready), 64'h1);
    step();
    gin.GLB_ifmap_valid = 1'b0;
    chk("t1_ids_zero_all_pe", 64'(gin.PE_valid), 64'(ALL));
    chk("t1_ifmap_class",     64'(gin.PE_class), 64'h0);
    gin.PE_ready = ALL;
    step();
    chk("t1_drain", 64'(gin.PE_valid), 64'h0);
    gin.PE_ready = '0;

    // 2: filter X = k%8, Y = row; tag 3/2 -> PE 19
    scan_load(1, 5'd0, 1, 3'd0);
    gin.filter_tag_X = 5'd3; gin.filter_tag_Y = 3'd2;
    gin.GLB_filter_valid = 1'b1; gin.PE_data_in = 32'hDEAD_BEEF;
    step();
    gin.GLB_filter_valid = 1'b0;
    chk("t2_pe_valid_bit19", 64'(gin.PE_valid), 64'h8_0000);
    chk("t2_pe_data",        64'(gin.PE_data),  64'hDEAD_BEEF);
    chk("t2_pe_class",       64'(gin.PE_class), 64'h1);
    gin.PE_ready = ALL;
    step();
    chk("t2_drain", 64'(gin.PE_valid), 64'h0);
    gin.PE_ready = '0;

    // 3: ifmap X all 0, tag 0/1 -> row 1 (bits 8..15), staggered readies
    gin.ifmap_tag_X = 5'd0; gin.ifmap_tag_Y = 3'd1;
    gin.GLB_ifmap_valid = 1'b1; gin.PE_data_in = 32'h0000_0033;
    settle();
    chk("t3_rdy_c0", 64'(gin.GLB_ifmap_ready), 64'h1);
    step();
    gin.PE_data_in = 32'h0000_0034;
    gin.PE_ready = 48'h0F00;
    chk("t3_valid_c1", 64'(gin.PE_valid), 64'hFF00);
    settle();
    chk("t3_rdy_c1", 64'(gin.GLB_ifmap_ready), 64'h0);
    step();
    gin.PE_ready = '0;
    chk("t3_valid_c2", 64'(gin.PE_valid), 64'hF000);
    settle();
    chk("t3_rdy_c2", 64'(gin.GLB_ifmap_ready), 64'h0);
    step();
    gin.PE_ready = 48'hF000;
    chk("t3_valid_c3", 64'(gin.PE_valid), 64'hF000);
    settle();
    chk("t3_rdy_c3", 64'(gin.GLB_ifmap_ready), 64'h1);
    step();
    gin.GLB_ifmap_valid = 1'b0;
    gin.PE_ready = ALL;
    chk("t3_reload_valid", 64'(gin.PE_valid), 64'hFF00);
    chk("t3_reload_data",  64'(gin.PE_data),  64'h34);
    step();
    chk("t3_drain", 64'(gin.PE_valid), 64'h0);

    // 4: 16 back-to-back ipsum words, tag 2/0 -> PE 2, all ready
    gin.ipsum_tag_X = 5'd2; gin.ipsum_tag_Y = 3'd0;
    gin.GLB_ipsum_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      gin.PE_data_in = 32'hA000_0000 + 32'(i);
      settle();
      chk($sformatf("t4_rdy_%0d", i), 64'(gin.GLB_ipsum_ready), 64'h1);
      step();
      chk($sformatf("t4_valid_%0d", i), 64'(gin.PE_valid), 64'h4);
      chk($sformatf("t4_data_%0d", i),  64'(gin.PE_data),  64'hA000_0000 + 64'(i));
    end
    gin.GLB_ipsum_valid = 1'b0;
    chk("t4_class", 64'(gin.PE_class), 64'h2);
    step();
    chk("t4_drain", 64'(gin.PE_valid), 64'h0);

    // 5: filter beats ifmap
    gin.filter_tag_X = 5'd3; gin.filter_tag_Y = 3'd2;
    gin.ifmap_tag_X  = 5'd0; gin.ifmap_tag_Y  = 3'd1;
    gin.GLB_filter_valid = 1'b1; gin.GLB_ifmap_valid = 1'b1;
    gin.PE_data_in = 32'h0000_0055;
    settle();
    chk("t5_filter_rdy", 64'(gin.GLB_filter_ready), 64'h1);
    chk("t5_ifmap_rdy",  64'(gin.GLB_ifmap_ready),  64'h0);
    step();
    gin.GLB_filter_valid = 1'b0;
    gin.PE_data_in = 32'h0000_0044;
    chk("t5_filter_class", 64'(gin.PE_class), 64'h1);
    chk("t5_filter_data",  64'(gin.PE_data),  64'h55);
    settle();
    chk("t5_ifmap_rdy_after", 64'(gin.GLB_ifmap_ready), 64'h1);
    step();
    gin.GLB_ifmap_valid = 1'b0;
    chk("t5_ifmap_class", 64'(gin.PE_class), 64'h0);
    chk("t5_ifmap_data",  64'(gin.PE_data),  64'h44);
    chk("t5_ifmap_valid", 64'(gin.PE_valid), 64'hFF00);
    step();

    // 6: zero-target word then an immediate good word
    gin.filter_tag_X = 5'd31; gin.filter_tag_Y = 3'd0;
    gin.GLB_filter_valid = 1'b1; gin.PE_data_in = 32'h0000_0066;
    settle();
    chk("t6_rdy_drop_word", 64'(gin.GLB_filter_ready), 64'h1);
    step();
    gin.filter_tag_X = 5'd3; gin.filter_tag_Y = 3'd2;
    gin.PE_data_in = 32'h0000_0077;
    chk("t6_drop_pulse",  64'(gin.drop_err), 64'h1);
    chk("t6_drop_no_pe",  64'(gin.PE_valid), 64'h0);
    settle();
    chk("t6_next_rdy", 64'(gin.GLB_filter_ready), 64'h1);
    step();
    gin.GLB_filter_valid = 1'b0;
    chk("t6_drop_cleared", 64'(gin.drop_err), 64'h0);
    chk("t6_next_valid",   64'(gin.PE_valid), 64'h8_0000);
    chk("t6_next_data",    64'(gin.PE_data),  64'h77);
    step();
    chk("t6_drain", 64'(gin.PE_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
